// File: rtl/conv3x3_pe4.sv
// conv3x3_pe4: four-lane 3x3 dot-product PE with a shadow/active weight bank
// and accumulation across input channels.
module conv3x3_pe4 #(
  parameter int WEIGHT_WIDTH = 8,
  parameter int PIXEL_WIDTH = 8,
  parameter int ACC_WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic weight_load,
  input  logic [9*WEIGHT_WIDTH-1:0] weight0,
  input  logic [9*WEIGHT_WIDTH-1:0] weight1,
  input  logic [9*WEIGHT_WIDTH-1:0] weight2,
  input  logic [9*WEIGHT_WIDTH-1:0] weight3,
  input  logic win_valid,
  input  logic win_last,
  input  logic [9*PIXEL_WIDTH-1:0] win_data,
  output logic win_ready,
  output logic busy,
  output logic out_valid,
  output logic [ACC_WIDTH-1:0] psum0,
  output logic [ACC_WIDTH-1:0] psum1,
  output logic [ACC_WIDTH-1:0] psum2,
  output logic [ACC_WIDTH-1:0] psum3
);
  localparam int PW = WEIGHT_WIDTH + PIXEL_WIDTH + 1;
  localparam int SW = PW + 4;

  typedef enum logic [1:0] {EMPTY, RUN, DRAIN} state_t;
  state_t state;

  logic [3:0][9*WEIGHT_WIDTH-1:0] wts, shadow, active;
  logic [3:0][8:0][PW-1:0] prod_c, s1_prod;
  logic [3:0][SW-1:0] sum_c, s2_sum;
  logic [3:0][ACC_WIDTH-1:0] acc, acc_next, psum;
  logic s1_v, s1_last, s2_v, s2_last, s3_v, acc_first;

  // signed weight times zero-extended pixel
  function automatic logic signed [PW-1:0] mul(input logic [WEIGHT_WIDTH-1:0] w,
                                               input logic [PIXEL_WIDTH-1:0] p);
    mul = $signed({{(PW-WEIGHT_WIDTH){w[WEIGHT_WIDTH-1]}}, w}) *
          $signed({{(PW-PIXEL_WIDTH){1'b0}}, p});
  endfunction

  assign wts = {weight3, weight2, weight1, weight0};
  assign win_ready = state == RUN;
  assign busy = s1_v | s2_v | s3_v;
  assign psum0 = psum[0];
  assign psum1 = psum[1];
  assign psum2 = psum[2];
  assign psum3 = psum[3];

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      sum_c[n] = '0;
      for (int k = 0; k < 9; k++) begin
        prod_c[n][k] = mul(active[n][(8-k)*WEIGHT_WIDTH +: WEIGHT_WIDTH],
                           win_data[(8-k)*PIXEL_WIDTH +: PIXEL_WIDTH]);
        sum_c[n] = sum_c[n] + {{(SW-PW){s1_prod[n][k][PW-1]}}, s1_prod[n][k]};
      end
      acc_next[n] = (acc_first ? '0 : acc[n]) + {{(ACC_WIDTH-SW){s2_sum[n][SW-1]}}, s2_sum[n]};
    end
  end

  // bank swap waits until no accepted window can still read the active bank
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= EMPTY;
      shadow <= '0;
      active <= '0;
    end else begin
      case (state)
        EMPTY: if (weight_load) begin
          active <= wts;
          state <= RUN;
        end
        RUN: if (weight_load) begin
          shadow <= wts;
          state <= DRAIN;
        end
        DRAIN: if (!s1_v && !s2_v) begin
          active <= weight_load ? wts : shadow;
          state <= RUN;
        end else if (weight_load) shadow <= wts;
        default: state <= EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_v <= 1'b0;
      s1_last <= 1'b0;
      s1_prod <= '0;
      s2_v <= 1'b0;
      s2_last <= 1'b0;
      s2_sum <= '0;
      s3_v <= 1'b0;
      out_valid <= 1'b0;
      acc <= '0;
      psum <= '0;
      acc_first <= 1'b1;
    end else begin
      s1_v <= win_valid && win_ready;
      s1_last <= win_last;
      s1_prod <= prod_c;
      s2_v <= s1_v;
      s2_last <= s1_last;
      s2_sum <= sum_c;
      s3_v <= s2_v;
      out_valid <= s2_v && s2_last;
      if (s2_v) begin
        acc <= acc_next;
        acc_first <= s2_last;
        if (s2_last) psum <= acc_next;
      end
    end
  end
endmodule

// File: tb/tb_conv3x3_pe4.sv
// tb_conv3x3_pe4: directed checks of weight banking, pipeline latency,
// channel accumulation and reset flush.
module tb_conv3x3_pe4;
  logic clk = 1'b0, rst = 1'b0, weight_load = 1'b0, win_valid = 1'b0, win_last = 1'b0;
  logic [71:0] weight0 = '0, weight1 = '0, weight2 = '0, weight3 = '0, win_data = '0;
  logic win_ready, busy, out_valid;
  logic [31:0] psum0, psum1, psum2, psum3;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  conv3x3_pe4 dut (
    .clk(clk), .rst(rst), .weight_load(weight_load),
    .weight0(weight0), .weight1(weight1), .weight2(weight2), .weight3(weight3),
    .win_valid(win_valid), .win_last(win_last), .win_data(win_data),
    .win_ready(win_ready), .busy(busy), .out_valid(out_valid),
    .psum0(psum0), .psum1(psum1), .psum2(psum2), .psum3(psum3)
  );

  function automatic logic [71:0] k(input logic [7:0] v);
    return {9{v}};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                         input logic [31:0] e2, input logic [31:0] e3);
    chk({tag, "_p0"}, psum0, e0);
    chk({tag, "_p1"}, psum1, e1);
    chk({tag, "_p2"}, psum2, e2);
    chk({tag, "_p3"}, psum3, e3);
  endtask

  task automatic set_w(input logic [71:0] a, input logic [71:0] b, input logic [71:0] c, input logic [71:0] d);
    weight0 = a;
    weight1 = b;
    weight2 = c;
    weight3 = d;
  endtask

  task automatic load(input logic [71:0] a, input logic [71:0] b, input logic [71:0] c, input logic [71:0] d);
    set_w(a, b, c, d);
    weight_load = 1'b1;
    tick;
    weight_load = 1'b0;
  endtask

  task automatic send(input logic [71:0] pix, input logic last);
    win_data = pix;
    win_valid = 1'b1;
    win_last = last;
    tick;
    win_valid = 1'b0;
    win_last = 1'b0;
  endtask

  initial begin
    int sent, got, first_c, last_c;
    logic [31:0] e0, e1;
    tick;
    tick;
    chk("rst_ready", win_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out", out_valid, 0);
    chk_all("rst", 0, 0, 0, 0);
    rst = 1'b1;
    tick;
    chk("empty_ready", win_ready, 0);

    // all ones
    load(k(8'h01), k(8'h01), k(8'h01), k(8'h01));
    chk("t1_ready", win_ready, 1);
    send(k(8'h01), 1'b1);
    chk("t1_busy", busy, 1);
    chk("t1_lat1", out_valid, 0);
    tick;
    chk("t1_lat2", out_valid, 0);
    tick;
    chk("t1_out", out_valid, 1);
    chk_all("t1", 9, 9, 9, 9);
    tick;
    chk("t1_pulse", out_valid, 0);
    chk("t1_hold", psum0, 9);
    chk("t1_idle", busy, 0);

    // signed weights against max pixels
    load(k(8'hFF), k(8'h02), k(8'h02), k(8'h02));
    chk("t2_drain", win_ready, 0);
    tick;
    chk("t2_run", win_ready, 1);
    send(k(8'hFF), 1'b1);
    tick;
    tick;
    chk("t2_out", out_valid, 1);
    chk_all("t2", 32'hFFFFF709, 4590, 4590, 4590);

    // three channels with a bank swap between each
    load(k(8'h01), k(8'h01), k(8'h01), k(8'h01));
    tick;
    send(k(8'h01), 1'b0);
    load(k(8'h02), k(8'h02), k(8'h02), k(8'h02));
    chk("t3_sw1_a", win_ready, 0);
    chk("t3_noout1", out_valid, 0);
    tick;
    chk("t3_sw1_b", win_ready, 0);
    tick;
    chk("t3_sw1_c", win_ready, 1);
    send(k(8'h01), 1'b0);
    load(k(8'h03), k(8'h03), k(8'h03), k(8'h03));
    chk("t3_sw2_a", win_ready, 0);
    tick;
    chk("t3_sw2_b", win_ready, 0);
    chk("t3_noout2", out_valid, 0);
    tick;
    chk("t3_sw2_c", win_ready, 1);
    send(k(8'h01), 1'b1);
    tick;
    chk("t3_noout3", out_valid, 0);
    tick;
    chk("t3_out", out_valid, 1);
    chk_all("t3", 54, 54, 54, 54);

    // eight back-to-back windows, swap requested with window 4
    set_w(k(8'hFE), k(8'h05), k(8'h05), k(8'h05));
    sent = 0;
    got = 0;
    first_c = -1;
    last_c = -1;
    for (int c = 0; c < 40 && got < 8; c++) begin
      win_valid = (sent < 8) && win_ready;
      win_last = 1'b1;
      win_data = k(8'(sent + 1));
      weight_load = win_valid && sent == 3;
      tick;
      if (win_valid) begin
        if (sent == 0) first_c = c;
        last_c = c;
        sent++;
      end
      win_valid = 1'b0;
      weight_load = 1'b0;
      if (out_valid) begin
        e0 = got < 4 ? 32'(27 * (got + 1)) : 32'(-18 * (got + 1));
        e1 = got < 4 ? 32'(27 * (got + 1)) : 32'(45 * (got + 1));
        chk_all($sformatf("t4_w%0d", got + 1), e0, e1, e1, e1);
        got++;
      end
    end
    win_last = 1'b0;
    chk("t4_count", 32'(got), 8);
    chk("t4_span", 32'(last_c - first_c), 10);

    // reset with windows in flight and a partial accumulation
    send(k(8'h01), 1'b0);
    send(k(8'h01), 1'b0);
    send(k(8'h01), 1'b0);
    send(k(8'h01), 1'b1);
    rst = 1'b0;
    tick;
    rst = 1'b1;
    chk("t5_busy", busy, 0);
    chk("t5_ready", win_ready, 0);
    chk_all("t5_rst", 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t5_noout%0d", i), out_valid, 0);
      tick;
    end
    chk("t5_still_empty", win_ready, 0);
    load(k(8'h01), k(8'h01), k(8'h01), k(8'h01));
    send(k(8'h01), 1'b1);
    tick;
    tick;
    chk("t5_out", out_valid, 1);
    chk_all("t5", 9, 9, 9, 9);

    // two loads during drain: the later one wins
    win_data = k(8'h01);
    win_valid = 1'b1;
    win_last = 1'b0;
    set_w(k(8'h02), k(8'h02), k(8'h02), k(8'h02));
    weight_load = 1'b1;
    tick;
    win_valid = 1'b0;
    weight_load = 1'b0;
    load(k(8'h03), k(8'h03), k(8'h03), k(8'h03));
    load(k(8'h04), k(8'h04), k(8'h04), k(8'h04));
    chk("t6_drain", win_ready, 0);
    tick;
    chk("t6_run", win_ready, 1);
    send(k(8'h01), 1'b1);
    tick;
    tick;
    chk("t6_out", out_valid, 1);
    chk_all("t6", 45, 45, 45, 45);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
